// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares a single-port data RAM between the core load/store unit
//             (port 0) and the debug/DMA loader (port 1). Arbitrates, range
//             checks each address, issues one RAM command at a time and
//             returns synchronous read data to the port that issued the read.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
   parameter logic [31:0] BASE_ADDR   = 32'h1024_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter bit          FIXED_PRIO  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   // port 0: core load/store unit
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [3:0]  p0_be,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_err,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   // port 1: debug / DMA loader
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [3:0]  p1_be,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_err,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   // RAM side, all driven from registers
   output logic        ram_we,
   output logic        ram_re,
   output logic        ram_rd_store,
   output logic        ram_rd_load,
   output logic [3:0]  ram_type,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdat,
   input  logic [31:0] ram_dout
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_RDWAIT = 2'd2
   } state_t;

   // One past the last legal byte address; 33 bits so the top of the map
   // never wraps around to zero.
   localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);

   state_t      state_q, state_d;
   logic        rr_last_q, rr_last_d;
   logic        rd_port_q, rd_port_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  err_q, err_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        ram_we_q, ram_we_d;
   logic        ram_re_q, ram_re_d;
   logic [3:0]  ram_type_q, ram_type_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [31:0] ram_wdat_q, ram_wdat_d;

   logic        sel_port;
   logic        sel_we;
   logic [3:0]  sel_be;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_legal;

   // Pick the winning port and decide whether its command may reach the RAM.
   always_comb begin
      sel_port = 1'b0;
      if (p0_req && p1_req)
         sel_port = FIXED_PRIO ? 1'b0 : ~rr_last_q;
      else if (p1_req)
         sel_port = 1'b1;

      sel_we    = sel_port ? p1_we    : p0_we;
      sel_be    = sel_port ? p1_be    : p0_be;
      sel_addr  = sel_port ? p1_addr  : p0_addr;
      sel_wdata = sel_port ? p1_wdata : p0_wdata;

      sel_legal = ({1'b0, sel_addr} >= {1'b0, BASE_ADDR}) &&
                  ({1'b0, sel_addr} <  ADDR_LIMIT) &&
                  (sel_be != 4'b0000);
   end

   // Next-state and next-output logic; pulses default low every cycle.
   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      rd_port_d  = rd_port_q;
      gnt_d      = 2'b00;
      err_d      = 2'b00;
      rvalid_d   = 2'b00;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      ram_we_d   = 1'b0;
      ram_re_d   = 1'b0;
      ram_type_d = ram_type_q;
      ram_addr_d = ram_addr_q;
      ram_wdat_d = ram_wdat_q;

      case (state_q)
         S_IDLE: begin
            if (p0_req || p1_req) begin
               state_d           = S_ISSUE;
               rr_last_d         = sel_port;
               rd_port_d         = sel_port;
               gnt_d[sel_port]   = 1'b1;
               if (sel_legal) begin
                  ram_addr_d = sel_addr;
                  ram_wdat_d = sel_wdata;
                  ram_type_d = sel_be;
                  ram_we_d   = sel_we;
                  ram_re_d   = ~sel_we;
               end else begin
                  // Rejected: RAM address/data/type keep their old values.
                  err_d[sel_port] = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            // Only a legal read needs the extra cycle for RAM data.
            state_d = ram_re_q ? S_RDWAIT : S_IDLE;
         end
         S_RDWAIT: begin
            rvalid_d[rd_port_q] = 1'b1;
            if (rd_port_q)
               rdata1_d = ram_dout;
            else
               rdata0_d = ram_dout;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_last_q  <= 1'b1;
         rd_port_q  <= 1'b0;
         gnt_q      <= 2'b00;
         err_q      <= 2'b00;
         rvalid_q   <= 2'b00;
         rdata0_q   <= 32'h0;
         rdata1_q   <= 32'h0;
         ram_we_q   <= 1'b0;
         ram_re_q   <= 1'b0;
         ram_type_q <= 4'h0;
         ram_addr_q <= 32'h0;
         ram_wdat_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         rd_port_q  <= rd_port_d;
         gnt_q      <= gnt_d;
         err_q      <= err_d;
         rvalid_q   <= rvalid_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         ram_we_q   <= ram_we_d;
         ram_re_q   <= ram_re_d;
         ram_type_q <= ram_type_d;
         ram_addr_q <= ram_addr_d;
         ram_wdat_q <= ram_wdat_d;
      end
   end

   assign p0_gnt       = gnt_q[0];
   assign p1_gnt       = gnt_q[1];
   assign p0_err       = err_q[0];
   assign p1_err       = err_q[1];
   assign p0_rvalid    = rvalid_q[0];
   assign p1_rvalid    = rvalid_q[1];
   assign p0_rdata     = rdata0_q;
   assign p1_rdata     = rdata1_q;
   assign ram_we       = ram_we_q;
   assign ram_re       = ram_re_q;
   assign ram_rd_store = ram_we_q;
   assign ram_rd_load  = ram_re_q;
   assign ram_type     = ram_type_q;
   assign ram_addr     = ram_addr_q;
   assign ram_wdat     = ram_wdat_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter: directed transactions,
//             a transaction-level reference model compared every cycle, and
//             a second instance with fixed priority for the contention case.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   localparam logic [31:0] BASE  = 32'h1024_0000;
   localparam int          DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [3:0]  p0_be, p1_be;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p0_err, p0_rvalid, p1_gnt, p1_err, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic        ram_we, ram_re, ram_rd_store, ram_rd_load;
   logic [3:0]  ram_type;
   logic [31:0] ram_addr, ram_wdat, ram_dout;

   // fixed-priority instance outputs
   logic        f_p0_gnt, f_p0_err, f_p0_rvalid, f_p1_gnt, f_p1_err, f_p1_rvalid;
   logic [31:0] f_p0_rdata, f_p1_rdata;
   logic        f_ram_we, f_ram_re, f_ram_rd_store, f_ram_rd_load;
   logic [3:0]  f_ram_type;
   logic [31:0] f_ram_addr, f_ram_wdat;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_err(p0_err), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_err(p1_err), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .ram_we(ram_we), .ram_re(ram_re), .ram_rd_store(ram_rd_store), .ram_rd_load(ram_rd_load),
      .ram_type(ram_type), .ram_addr(ram_addr), .ram_wdat(ram_wdat), .ram_dout(ram_dout)
   );

   dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .FIXED_PRIO(1'b1)) dut_fix (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(f_p0_gnt), .p0_err(f_p0_err), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(f_p1_gnt), .p1_err(f_p1_err), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
      .ram_we(f_ram_we), .ram_re(f_ram_re), .ram_rd_store(f_ram_rd_store), .ram_rd_load(f_ram_rd_load),
      .ram_type(f_ram_type), .ram_addr(f_ram_addr), .ram_wdat(f_ram_wdat), .ram_dout(32'h0)
   );

   // ---------------------------------------------------------------- RAM ---
   logic [31:0] ram_mem [0:DEPTH-1];
   logic [31:0] ram_off;
   assign ram_off = ram_addr - BASE;

   initial begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = 32'hA500_0000 | 32'(i);
   end

   always @(posedge clk) begin
      if (ram_we)
         for (int b = 0; b < 4; b++)
            if (ram_type[b]) ram_mem[ram_off[11:2]][8*b +: 8] <= ram_wdat[8*b +: 8];
      if (ram_re)
         ram_dout <= ram_mem[ram_off[11:2]];
   end

   // ------------------------------------------------------ reference model --
   // Transaction level: an arbiter that is either free or busy for a known
   // number of edges, plus its own copy of RAM contents.
   logic [31:0] m_mem [0:DEPTH-1];
   int          m_busy, m_rv_cnt, m_rv_port;
   logic [31:0] m_rv_data;
   logic        m_rr_last;
   logic [1:0]  e_gnt, e_err, e_rv;
   logic [31:0] e_rd [2];
   logic        e_we, e_re;
   logic [3:0]  e_type;
   logic [31:0] e_addr, e_wdat;

   task automatic model_step();
      int          p;
      logic        we;
      logic [3:0]  be;
      logic [31:0] a, d, off;
      longint unsigned la;
      if (rst) begin
         m_busy = 0; m_rv_cnt = 0; m_rv_port = 0; m_rv_data = 0; m_rr_last = 1'b1;
         e_gnt = 0; e_err = 0; e_rv = 0; e_rd[0] = 0; e_rd[1] = 0;
         e_we = 0; e_re = 0; e_type = 0; e_addr = 0; e_wdat = 0;
         return;
      end
      e_gnt = 0; e_err = 0; e_rv = 0; e_we = 0; e_re = 0;
      if (m_rv_cnt > 0) begin
         m_rv_cnt--;
         if (m_rv_cnt == 0) begin
            e_rv[m_rv_port]   = 1'b1;
            e_rd[m_rv_port]   = m_rv_data;
         end
      end
      if (m_busy > 0) begin
         m_busy--;
      end else if (p0_req || p1_req) begin
         if (p0_req && p1_req) p = m_rr_last ? 0 : 1;
         else                  p = p0_req ? 0 : 1;
         we = p ? p1_we : p0_we;
         be = p ? p1_be : p0_be;
         a  = p ? p1_addr : p0_addr;
         d  = p ? p1_wdata : p0_wdata;
         m_rr_last = (p == 1);
         e_gnt[p]  = 1'b1;
         la = 64'(a);
         if (la < 64'(BASE) || la >= 64'(BASE) + 64'(4 * DEPTH) || be == 4'h0) begin
            e_err[p] = 1'b1;
            m_busy   = 1;
         end else begin
            e_addr = a; e_wdat = d; e_type = be;
            off = a - BASE;
            if (we) begin
               e_we = 1'b1;
               for (int b = 0; b < 4; b++)
                  if (be[b]) m_mem[off[11:2]][8*b +: 8] = d[8*b +: 8];
               m_busy = 1;
            end else begin
               e_re      = 1'b1;
               m_rv_cnt  = 2;
               m_rv_port = p;
               m_rv_data = m_mem[off[11:2]];
               m_busy    = 2;
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hA500_0000 | 32'(i);
      forever begin
         @(posedge clk or posedge rst);
         model_step();
      end
   end

   // ------------------------------------------------------------ helpers ---
   function automatic logic [159:0] out_vec();
      return {18'h0, p0_gnt, p1_gnt, p0_err, p1_err, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
              ram_we, ram_re, ram_rd_store, ram_rd_load, ram_type, ram_addr, ram_wdat};
   endfunction

   function automatic logic [159:0] exp_vec();
      return {18'h0, e_gnt[0], e_gnt[1], e_err[0], e_err[1], e_rv[0], e_rv[1], e_rd[0], e_rd[1],
              e_we, e_re, e_we, e_re, e_type, e_addr, e_wdat};
   endfunction

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // every cycle: DUT against model
   initial begin
      forever begin
         @(negedge clk);
         chk("cycle_model", out_vec(), exp_vec());
      end
   end

   task automatic set_port(input int p, input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         p0_req = 1'b1; p0_we = we; p0_be = be; p0_addr = a; p0_wdata = d;
      end else begin
         p1_req = 1'b1; p1_we = we; p1_be = be; p1_addr = a; p1_wdata = d;
      end
   endtask

   function automatic logic [1:0] onehot(input int p);
      return (p == 0) ? 2'b01 : 2'b10;
   endfunction

   // legal read with literal latency/data expectations
   task automatic read_op(input int p, input logic [31:0] a, input logic [31:0] exp, input string nm);
      set_port(p, 1'b0, 4'hF, a, 32'h0);
      @(negedge clk);
      chk({nm, "_issue"}, {p1_gnt, p0_gnt, p1_err, p0_err, ram_re, ram_we},
          {onehot(p), 2'b00, 1'b1, 1'b0});
      p0_req = 1'b0; p1_req = 1'b0;
      @(negedge clk);
      chk({nm, "_wait"}, {p1_rvalid, p0_rvalid}, 2'b00);
      @(negedge clk);
      chk({nm, "_rvalid"}, {p1_rvalid, p0_rvalid}, onehot(p));
      chk({nm, "_rdata"}, (p == 0) ? p0_rdata : p1_rdata, exp);
   endtask

   // rejected command: gnt+err together, no strobe, no rvalid
   task automatic err_op(input int p, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input string nm);
      set_port(p, we, be, a, 32'hDEAD_BEEF);
      @(negedge clk);
      chk({nm, "_gnt_err"}, {p1_gnt, p0_gnt, p1_err, p0_err, ram_re, ram_we},
          {onehot(p), onehot(p), 2'b00});
      p0_req = 1'b0; p1_req = 1'b0;
      @(negedge clk);
      chk({nm, "_no_rvalid"}, {p1_rvalid, p0_rvalid, ram_re, ram_we}, 4'b0000);
      @(negedge clk);
      chk({nm, "_no_rvalid2"}, {p1_rvalid, p0_rvalid}, 2'b00);
   endtask

   // ------------------------------------------------------------ stimulus --
   logic [7:0] rr_log, fx_log;
   int         rr_n, fx_n;

   initial begin
      rst = 1'b1;
      p0_req = 0; p0_we = 0; p0_be = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_be = 0; p1_addr = 0; p1_wdata = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", out_vec(), 160'h0);
      rst = 1'b0;
      @(negedge clk);

      // single store from port 0
      set_port(0, 1'b1, 4'hF, 32'h1024_0083, 32'h0001_2567);
      @(negedge clk);
      chk("wr_gnt", {p0_gnt, p0_err, p1_gnt}, 3'b100);
      chk("wr_strobes", {ram_we, ram_rd_store, ram_re, ram_rd_load}, 4'b1100);
      chk("wr_addr", ram_addr, 32'h1024_0083);
      chk("wr_type_data", {ram_type, ram_wdat}, {4'hF, 32'h0001_2567});
      p0_req = 1'b0;
      @(negedge clk);

      // read-back, then port 1 range checks
      read_op(0, 32'h1024_0083, 32'h0001_2567, "rdback");
      err_op(1, 1'b0, 4'hF, 32'h1024_1000, "p1_past_end");
      err_op(1, 1'b0, 4'hF, 32'h1023_FFFC, "p1_below_base");
      read_op(1, 32'h1024_0FFC, 32'hA500_03FF, "p1_last_word");

      // contention: both ports store for 8 cycles, then p0 drops out
      rr_log = 0; fx_log = 0; rr_n = 0; fx_n = 0;
      set_port(0, 1'b1, 4'hF, 32'h1024_0010, 32'h0000_AAAA);
      set_port(1, 1'b1, 4'hF, 32'h1024_0014, 32'h0000_BBBB);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (p0_gnt)   begin rr_log = {rr_log[6:0], 1'b0}; rr_n++; end
         if (p1_gnt)   begin rr_log = {rr_log[6:0], 1'b1}; rr_n++; end
         if (f_p0_gnt) begin fx_log = {fx_log[6:0], 1'b0}; fx_n++; end
         if (f_p1_gnt) begin fx_log = {fx_log[6:0], 1'b1}; fx_n++; end
         if (i == 7) p0_req = 1'b0;
      end
      p1_req = 1'b0;
      chk("rr_grant_order", {8'(rr_n), rr_log}, {8'd6, 8'b0001_0111});
      chk("fixed_grant_order", {8'(fx_n), fx_log}, {8'd6, 8'b0000_0011});
      repeat (2) @(negedge clk);

      // be=0 store must not touch RAM
      err_op(0, 1'b1, 4'h0, 32'h1024_0083, "p0_be_zero");
      read_op(0, 32'h1024_0083, 32'h0001_2567, "be0_rdback");
      read_op(1, 32'h1024_0010, 32'h0000_AAAA, "cont_rdback");

      // reset while a read is in RDWAIT
      set_port(1, 1'b0, 4'hF, 32'h1024_0083, 32'h0);
      @(negedge clk);
      chk("midrst_issue", {p1_gnt, ram_re}, 2'b11);
      p1_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_outputs", out_vec(), 160'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_no_rvalid", {p1_rvalid, p0_rvalid, p1_rdata}, 34'h0);
      @(negedge clk);
      chk("midrst_no_rvalid2", {p1_rvalid, p0_rvalid}, 2'b00);

      // first tie after reset goes to port 0
      set_port(0, 1'b1, 4'hF, 32'h1024_0040, 32'h1111_2222);
      set_port(1, 1'b1, 4'hF, 32'h1024_0044, 32'h3333_4444);
      @(negedge clk);
      chk("tie_after_rst", {p0_gnt, p1_gnt, ram_addr}, {2'b10, 32'h1024_0040});
      p0_req = 1'b0; p1_req = 1'b0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port data RAM between the core load/store unit (port 0) and the debug/DMA loader (port 1).
- Arbitrates with round-robin or fixed priority, range-checks each address, and issues one RAM command at a time.
- Captures the RAM's synchronous read data and returns it to the requester that issued the read.
- Sits between the requesters and the data RAM; every RAM-side signal comes from a register.

Parameters:
- BASE_ADDR, 32'h1024_0000, byte address of RAM word 0.
- DEPTH_WORDS, 1024, RAM size in 32-bit words. Valid range is BASE_ADDR ≤ addr < BASE_ADDR + 4*DEPTH_WORDS.
- FIXED_PRIO, 0. 1 = port 0 always wins; 0 = round-robin.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- p0_req, p1_req  in  1  request; held with its command fields until the matching gnt
- p0_we, p1_we  in  1  1 = store, 0 = load
- p0_be, p1_be  in  4  byte enables, passed to ram_type
- p0_addr, p1_addr  in  32  byte address
- p0_wdata, p1_wdata  in  32  store data
- p0_gnt, p1_gnt  out  1  one-cycle grant pulse
- p0_err, p1_err  out  1  one-cycle error pulse, coincident with gnt
- p0_rvalid, p1_rvalid  out  1  one-cycle read-data-valid pulse
- p0_rdata, p1_rdata  out  32  read data, valid while rvalid
- ram_we, ram_re, ram_rd_store, ram_rd_load  out  1  RAM strobes; ram_rd_store = ram_we, ram_rd_load = ram_re
- ram_type  out  4  byte enables to RAM
- ram_addr, ram_wdat  out  32  RAM address / write data
- ram_dout  in  32  RAM read data, valid one cycle after ram_re

Behaviour:
- Reset: all outputs 0, state IDLE, rr_last = 1 (port 0 wins the first tie). Reset is asynchronous: an in-flight read is dropped and no rvalid is produced.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE, no request: state stays IDLE, all RAM strobes 0.
- IDLE, selection rule:
  - Only one req high: that port is selected.
  - Both high with FIXED_PRIO=1: port 0 is selected.
  - Both high with FIXED_PRIO=0: the port ≠ rr_last is selected.
- IDLE, at the clock edge after selection:
  - rr_last ← selected port.
  - gnt_sel ← 1.
  - State → ISSUE.
- Legal command (addr in range, be≠0):
  - ram_addr, ram_wdat and ram_type are registered from the selected port.
  - ram_we ← we, ram_re ← ~we.
- Illegal command (addr out of range, or be=0):
  - err_sel ← 1; no RAM strobe is asserted.
  - ram_addr, ram_wdat and ram_type keep their previous values.
- ISSUE (one cycle):
  - gnt/err visible this cycle; the RAM executes the command at the end of this cycle.
  - Next: gnt, err, ram_we, ram_re ← 0.
  - State → RDWAIT for a legal read, else → IDLE.
  - Requests are ignored while in ISSUE and RDWAIT.
- RDWAIT (one cycle): ram_dout is valid. At the edge:
  - rdata_sel ← ram_dout, rvalid_sel ← 1, state → IDLE.
- rvalid lasts exactly one cycle. rdata holds its value until the next read to the same port.
- The unselected port's rdata/rvalid are never disturbed.
- Latency from the request being sampled in IDLE (cycle T):
  - gnt at T+1.
  - Write lands in RAM at the end of T+1.
  - Read rvalid at T+3.
- Throughput: a new arbitration may occur in the same cycle rvalid is high (IDLE at T+3). Writes sustain one per 2 cycles; reads one per 3.
- Range check uses full 32-bit unsigned compares with no wrap-around. ram_addr is the unmodified byte address.
- A requester dropping req before gnt is legal; the arbiter re-evaluates every IDLE cycle.
- rr_last updates on error grants too.

Test Plan:
- Reset then single write: p0 stores wdata 0x0001_2567, be 4'b1111, addr 0x1024_0083 → p0_gnt at T+1 with ram_we=1, ram_rd_store=1, ram_addr=0x1024_0083, ram_type=4'hF; p0_err=0.
- Read-back: p0 loads addr 0x1024_0083 → ram_re=1 at T+1, p0_rvalid=1 with p0_rdata=0x0001_2567 at T+3; p1_rvalid stays 0.
- Round-robin contention: both ports hold write requests for 8 cycles → gnt alternates p0, p1, p0, p1 every 2 cycles. With FIXED_PRIO=1, only p0 is granted until it drops req.
- Range errors, port 1:
  - Load to 0x1024_1000 (one past the end) → p1_gnt and p1_err high together, ram_re stays 0, no rvalid.
  - Load to 0x1023_FFFC → same result.
  - Load to 0x1024_0FFC → accepted.
- be=0 store → err pulse, ram_we never asserted, RAM contents unchanged (verified by a later read).
- Mid-read reset: assert rst during RDWAIT → outputs 0 immediately, no rvalid after release. The first request after reset is a tie, and p0 wins it.
